// File: rtl/memory_stage.sv
// RV64 MEM stage: data-memory load/store over a req/ack bus, load alignment/extension,
// misalign and access-fault detection, and the registered writeback interface.
module memory_stage #(
    parameter int XLEN         = 64,
    parameter int DMEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_v,
    input  logic [31:0]     mem_ir,
    input  logic [XLEN-1:0] mem_npc,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_csrfd,
    input  logic [XLEN-1:0] mem_rfd,
    input  logic [XLEN-1:0] mem_sr2,
    input  logic [4:0]      mem_drid,
    input  logic            mem_pc_mux,
    input  logic            mem_ecall,
    input  logic            wb_flush,
    output logic            mem_stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    input  logic            dmem_err,
    output logic            wb_v,
    output logic [31:0]     wb_ir,
    output logic [XLEN-1:0] wb_npc,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_mem_result,
    output logic [XLEN-1:0] wb_csrfd,
    output logic [XLEN-1:0] wb_rfd,
    output logic [4:0]      wb_drid,
    output logic            wb_pc_mux,
    output logic            wb_ecall,
    output logic            mem_lam,
    output logic            mem_laf,
    output logic            mem_sam,
    output logic            mem_saf
);
    // state  | meaning
    // IDLE   | pass-through; aligned mem-op launches a bus access
    // ACCESS | request held on the bus until ACK/ERR/timeout
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam int CW = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(DMEM_TIMEOUT);

    state_t state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            flushed;
    logic [31:0]     acc_ir;
    logic [XLEN-1:0] acc_npc, acc_addr, acc_csrfd, acc_rfd, acc_sr2;
    logic [4:0]      acc_drid;
    logic            acc_pc_mux, acc_ecall;

    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        return {&sz, sz[1], |sz};
    endfunction

    function automatic logic [7:0] size_strb(input logic [1:0] sz);
        case (sz)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    logic [2:0] in_f3;
    logic       in_load, in_store, in_misaligned, start;
    assign in_f3         = mem_ir[14:12];
    assign in_load       = (mem_ir[6:0] == 7'b0000011) && (in_f3 != 3'b111);
    assign in_store      = (mem_ir[6:0] == 7'b0100011) && !in_f3[2];
    assign in_misaligned = (in_load || in_store) &&
                           ((mem_alu_result[2:0] & align_mask(in_f3[1:0])) != 3'b000);
    assign start         = mem_v && (in_load || in_store) && !in_misaligned && !wb_flush;

    logic            in_access, acc_load, done, fault, keep;
    logic [2:0]      acc_off;
    logic [XLEN-1:0] rd_shift, load_val;
    assign in_access = (state == ACCESS);
    assign acc_load  = !acc_ir[5];
    assign acc_off   = acc_addr[2:0];
    assign done      = in_access && (dmem_ack || dmem_err || cnt == TMO);
    assign fault     = dmem_err || !dmem_ack;
    assign keep      = !(flushed || wb_flush);
    assign rd_shift  = dmem_rdata >> {acc_off, 3'b000};

    always_comb begin
        load_val = '0;
        case (acc_ir[14:12])
            3'd0: load_val = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
            3'd1: load_val = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
            3'd2: load_val = {{(XLEN-32){rd_shift[31]}}, rd_shift[31:0]};
            3'd3: load_val = rd_shift;
            3'd4: load_val = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
            3'd5: load_val = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
            3'd6: load_val = {{(XLEN-32){1'b0}}, rd_shift[31:0]};
            default: load_val = '0;
        endcase
    end

    assign dmem_req   = in_access;
    assign dmem_we    = in_access && !acc_load;
    assign dmem_addr  = in_access ? {acc_addr[XLEN-1:3], 3'b000} : '0;
    assign dmem_wstrb = dmem_we ? (size_strb(acc_ir[13:12]) << acc_off) : 8'h00;
    assign dmem_wdata = dmem_we ? (acc_sr2 << {acc_off, 3'b000}) : '0;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = ACCESS;
                mem_stall = !reset;
            end
            ACCESS: begin
                mem_stall = !done && !reset;
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0; flushed <= 1'b0;
            acc_ir <= '0; acc_npc <= '0; acc_addr <= '0; acc_csrfd <= '0; acc_rfd <= '0;
            acc_sr2 <= '0; acc_drid <= '0; acc_pc_mux <= 1'b0; acc_ecall <= 1'b0;
            wb_v <= 1'b0; wb_ir <= '0; wb_npc <= '0; wb_alu_result <= '0; wb_mem_result <= '0;
            wb_csrfd <= '0; wb_rfd <= '0; wb_drid <= '0; wb_pc_mux <= 1'b0; wb_ecall <= 1'b0;
            mem_lam <= 1'b0; mem_laf <= 1'b0; mem_sam <= 1'b0; mem_saf <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                cnt <= '0; flushed <= 1'b0;
                acc_ir <= mem_ir; acc_npc <= mem_npc; acc_addr <= mem_alu_result;
                acc_csrfd <= mem_csrfd; acc_rfd <= mem_rfd; acc_sr2 <= mem_sr2;
                acc_drid <= mem_drid; acc_pc_mux <= mem_pc_mux; acc_ecall <= mem_ecall;
                wb_v <= 1'b0;
                mem_lam <= 1'b0; mem_laf <= 1'b0; mem_sam <= 1'b0; mem_saf <= 1'b0;
            end else begin
                wb_v <= mem_v && !wb_flush;
                wb_ir <= mem_ir; wb_npc <= mem_npc; wb_alu_result <= mem_alu_result;
                wb_mem_result <= '0; wb_csrfd <= mem_csrfd; wb_rfd <= mem_rfd;
                wb_drid <= mem_drid; wb_pc_mux <= mem_pc_mux; wb_ecall <= mem_ecall;
                mem_lam <= mem_v && !wb_flush && in_misaligned && in_load;
                mem_sam <= mem_v && !wb_flush && in_misaligned && in_store;
                mem_laf <= 1'b0; mem_saf <= 1'b0;
            end
        end else begin
            // a flush seen at any point of the access squashes its eventual result
            if (wb_flush) flushed <= 1'b1;
            if (done) begin
                wb_v <= keep;
                wb_ir <= acc_ir; wb_npc <= acc_npc; wb_alu_result <= acc_addr;
                wb_mem_result <= (acc_load && !fault) ? load_val : '0;
                wb_csrfd <= acc_csrfd; wb_rfd <= acc_rfd; wb_drid <= acc_drid;
                wb_pc_mux <= acc_pc_mux; wb_ecall <= acc_ecall;
                mem_laf <= keep && fault && acc_load;
                mem_saf <= keep && fault && !acc_load;
                mem_lam <= 1'b0; mem_sam <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
